// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-stage bundle: redirect/stall in, imem handshake, IF/ID out
interface fetch_ctrl_if #(
   parameter int WORD = 32
);
   logic            br_taken;
   logic [WORD-1:0] br_dest;
   logic            stall;
   logic            imem_req;
   logic [WORD-1:0] imem_addr;
   logic            imem_ack;
   logic [WORD-1:0] imem_rdata;
   logic            ifid_valid;
   logic [WORD-1:0] ifid_ir;
   logic [WORD-1:0] ifid_npc;
   logic            fetch_err;

   modport master (
      input  br_taken, br_dest, stall, imem_ack, imem_rdata,
      output imem_req, imem_addr, ifid_valid, ifid_ir, ifid_npc, fetch_err
   );

   modport slave (
      output br_taken, br_dest, stall, imem_ack, imem_rdata,
      input  imem_req, imem_addr, ifid_valid, ifid_ir, ifid_npc, fetch_err
   );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC, imem req/ack, one-entry skid, redirect, timeout
module fetch_ctrl #(
   parameter int              WORD     = 32,
   parameter logic [WORD-1:0] STEP     = 32'd1,
   parameter logic [WORD-1:0] RESET_PC = 32'd0,
   parameter int              MAX_WAIT = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   fetch_ctrl_if.master  io_bus
);
   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_ERR   = 2'd2;

   localparam int             WW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0]  WAIT_LAST = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

   logic [1:0]      r_state;
   logic            r_run;
   logic [WORD-1:0] r_pc;
   logic            r_valid;
   logic [WORD-1:0] r_ir;
   logic [WORD-1:0] r_npc;
   logic [WORD-1:0] r_skid_ir;
   logic [WORD-1:0] r_skid_npc;
   logic [WW-1:0]   r_wait;

   logic            w_req;
   logic            w_ack;
   logic            w_redirect;
   logic            w_timeout;
   logic [WORD-1:0] w_pc_next;

   // r_run keeps the request low until the first edge after reset is released
   assign w_req      = r_run && (r_state == S_FETCH);
   assign w_ack      = w_req && io_bus.imem_ack;
   assign w_redirect = io_bus.br_taken && (r_state != S_ERR);
   assign w_timeout  = (MAX_WAIT > 0) && w_req && !io_bus.imem_ack && (r_wait == WAIT_LAST);
   assign w_pc_next  = r_pc + STEP;

   assign io_bus.imem_req   = w_req;
   assign io_bus.imem_addr  = r_pc;
   assign io_bus.ifid_valid = r_valid;
   assign io_bus.ifid_ir    = r_ir;
   assign io_bus.ifid_npc   = r_npc;
   assign io_bus.fetch_err  = (r_state == S_ERR);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_FETCH;
         r_run      <= 1'b0;
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_ir       <= '0;
         r_npc      <= '0;
         r_skid_ir  <= '0;
         r_skid_npc <= '0;
         r_wait     <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_redirect) begin
            r_pc    <= io_bus.br_dest;
            r_valid <= 1'b0;
            r_wait  <= '0;
            r_state <= S_FETCH;
         end else begin
            case (r_state)
               S_FETCH: begin
                  if (w_ack) begin
                     r_pc   <= w_pc_next;
                     r_wait <= '0;
                     if (io_bus.stall) begin
                        r_skid_ir  <= io_bus.imem_rdata;
                        r_skid_npc <= w_pc_next;
                        r_state    <= S_HOLD;
                     end else begin
                        r_valid <= 1'b1;
                        r_ir    <= io_bus.imem_rdata;
                        r_npc   <= w_pc_next;
                     end
                  end else begin
                     if (!io_bus.stall) begin
                        r_valid <= 1'b0;
                     end
                     if (w_req) begin
                        r_wait <= r_wait + WW'(1);
                     end
                     if (w_timeout) begin
                        r_valid <= 1'b0;
                        r_state <= S_ERR;
                     end
                  end
               end
               S_HOLD: begin
                  if (!io_bus.stall) begin
                     r_valid <= 1'b1;
                     r_ir    <= r_skid_ir;
                     r_npc   <= r_skid_npc;
                     r_state <= S_FETCH;
                  end
               end
               default: begin
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
   localparam int MAXW = 16;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] npc;
   } held_t;

   logic        clk;
   logic        rst;
   logic        br;
   logic [31:0] dest;
   logic        stall;
   logic        ack;

   int n_cmp;
   int n_bad;

   logic        m_run;
   logic        m_err;
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   logic [31:0] m_npc;
   int          m_waits;
   held_t       held_q[$];

   fetch_ctrl_if #(.WORD(32)) bus ();
   fetch_ctrl_if #(.WORD(32)) bus2 ();

   assign bus.br_taken   = br;
   assign bus.br_dest    = dest;
   assign bus.stall      = stall;
   assign bus.imem_ack   = ack;
   assign bus.imem_rdata = 32'h1000 + bus.imem_addr;

   assign bus2.br_taken   = 1'b0;
   assign bus2.br_dest    = 32'd0;
   assign bus2.stall      = 1'b0;
   assign bus2.imem_ack   = 1'b1;
   assign bus2.imem_rdata = 32'h1000 + bus2.imem_addr;

   fetch_ctrl #(.WORD(32), .STEP(32'd1), .RESET_PC(32'd0), .MAX_WAIT(MAXW)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   fetch_ctrl #(.WORD(32), .STEP(32'd1), .RESET_PC(32'hFFFF_FFFF), .MAX_WAIT(0)) u_dut_wrap (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_pc    = 32'd0;
      m_ir    = 32'd0;
      m_npc   = 32'd0;
      m_waits = 0;
      held_q.delete();
   endtask

   // One clock of fetch behaviour, from the inputs present before the edge
   task automatic model_step();
      logic req;
      req   = m_run && !m_err && (held_q.size() == 0);
      m_run = 1'b1;
      if (m_err) begin
      end else if (br) begin
         m_pc    = dest;
         m_valid = 1'b0;
         m_waits = 0;
         held_q.delete();
      end else if (held_q.size() != 0) begin
         if (!stall) begin
            m_valid = 1'b1;
            m_ir    = held_q[0].ir;
            m_npc   = held_q[0].npc;
            void'(held_q.pop_front());
         end
      end else if (req && ack) begin
         held_t w;
         w.ir    = 32'h1000 + m_pc;
         w.npc   = m_pc + 32'd1;
         m_pc    = w.npc;
         m_waits = 0;
         if (stall) begin
            held_q.push_back(w);
         end else begin
            m_valid = 1'b1;
            m_ir    = w.ir;
            m_npc   = w.npc;
         end
      end else begin
         if (!stall) m_valid = 1'b0;
         if (req) begin
            m_waits++;
            if (m_waits == MAXW) begin
               m_err   = 1'b1;
               m_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      check("imem_req", 32'(bus.imem_req), 32'(m_run && !m_err && (held_q.size() == 0)));
      check("imem_addr", bus.imem_addr, m_pc);
      check("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
      check("fetch_err", 32'(bus.fetch_err), 32'(m_err));
      if (m_valid) begin
         check("ifid_ir", bus.ifid_ir, m_ir);
         check("ifid_npc", bus.ifid_npc, m_npc);
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; br = 1'b0; dest = 32'd0; stall = 1'b0; ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ir", bus.ifid_ir, 32'd0);
      check("rst_npc", bus.ifid_npc, 32'd0);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFF);

      // zero-wait stream
      ack = 1'b1; rst = 1'b0;
      cyc();
      check("first_req", 32'(bus.imem_req), 32'd1);
      check("first_valid", 32'(bus.ifid_valid), 32'd0);
      cyc();
      check("zw_ir0", bus.ifid_ir, 32'h1000);
      check("zw_npc0", bus.ifid_npc, 32'd1);
      check("wrap_npc", bus2.ifid_npc, 32'd0);
      check("wrap_ir", bus2.ifid_ir, 32'h0000_0FFF);
      check("wrap_addr", bus2.imem_addr, 32'd0);
      cyc();
      check("zw_ir1", bus.ifid_ir, 32'h1001);
      check("zw_npc1", bus.ifid_npc, 32'd2);
      check("wrap_ir1", bus2.ifid_ir, 32'h1000);
      cyc();
      check("zw_ir2", bus.ifid_ir, 32'h1002);
      check("zw_npc2", bus.ifid_npc, 32'd3);

      // wait states: ack every third cycle
      for (int k = 0; k < 9; k++) begin
         ack = (k % 3 == 2);
         cyc();
      end

      // stall with skid
      ack = 1'b1; br = 1'b1; dest = 32'h20;
      cyc();
      br = 1'b0;
      cyc();
      check("pre_stall_ir", bus.ifid_ir, 32'h1020);
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("stall_ir", bus.ifid_ir, 32'h1020);
         check("hold_req", 32'(bus.imem_req), 32'd0);
      end
      stall = 1'b0;
      cyc();
      check("skid_ir", bus.ifid_ir, 32'h1021);
      check("skid_npc", bus.ifid_npc, 32'h22);
      cyc();
      check("post_skid_ir", bus.ifid_ir, 32'h1022);

      // redirect while stalled with a full skid
      stall = 1'b1;
      cyc();
      br = 1'b1; dest = 32'h40;
      cyc();
      check("redir_addr", bus.imem_addr, 32'h40);
      check("redir_valid", 32'(bus.ifid_valid), 32'd0);
      br = 1'b0; stall = 1'b0;
      cyc();
      check("redir_ir", bus.ifid_ir, 32'h1040);
      check("redir_npc", bus.ifid_npc, 32'h41);

      // timeout
      ack = 1'b0; br = 1'b1; dest = 32'h50;
      cyc();
      br = 1'b0;
      repeat (15) cyc();
      check("to_not_yet", 32'(bus.fetch_err), 32'd0);
      cyc();
      check("to_err", 32'(bus.fetch_err), 32'd1);
      check("to_req", 32'(bus.imem_req), 32'd0);
      br = 1'b1; dest = 32'h60;
      cyc();
      br = 1'b0;
      check("err_ignores_br", bus.imem_addr, 32'h50);
      #2 rst = 1'b1;
      #1;
      check("err_async_clear", 32'(bus.fetch_err), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset asserted mid-wait
      cyc();
      br = 1'b1; dest = 32'h33;
      cyc();
      br = 1'b0;
      cyc();
      cyc();
      check("mid_wait_req", 32'(bus.imem_req), 32'd1);
      check("mid_wait_addr", bus.imem_addr, 32'h33);
      #2 rst = 1'b1;
      #1;
      check("async_req_low", 32'(bus.imem_req), 32'd0);
      check("async_pc", bus.imem_addr, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; ack = 1'b1;
      cyc();
      cyc();
      check("restart_ir", bus.ifid_ir, 32'h1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
